// File: rtl/icache_pkg.sv
// Shared geometry, state encoding and constants for the instruction cache.
package icache_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned OFF_W  = 2;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int unsigned LINES  = 1 << IDX_W;
  localparam int unsigned WORDS  = 1 << (IDX_W + OFF_W);
  localparam int unsigned CNT_W  = 16;

  // Instruction handed to decode whenever no valid word is available.
  localparam logic [DATA_W-1:0] NOP = 16'h0000;

  typedef enum logic {
    IC_IDLE   = 1'b0,
    IC_REFILL = 1'b1
  } state_t;

  // Saturating increment for the performance counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/icache_line_ram.sv
// Data array: 32 x 16, combinational read, synchronous write, no reset.
module icache_line_ram
  import icache_pkg::*;
(
  input  logic                     clock,
  input  logic                     we,
  input  logic [IDX_W+OFF_W-1:0]   waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [IDX_W+OFF_W-1:0]   raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [WORDS];

  // Refill writes one word per cycle.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with 4-word line refill.
module icache
  import icache_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              flush,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [OFF_W-1:0] req_off;

  assign req_tag = cpu_addr[ADDR_W-1 -: TAG_W];
  assign req_idx = cpu_addr[OFF_W +: IDX_W];
  assign req_off = cpu_addr[OFF_W-1:0];

  state_t           state, next_state;
  logic [OFF_W-1:0] cnt;
  logic [TAG_W-1:0] line_tag;
  logic [IDX_W-1:0] line_idx;
  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags [LINES];

  logic              hit;
  logic              hit_inc;
  logic              miss_inc;
  logic              start_refill;
  logic              fill_done;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;

  assign hit = cpu_req & valid[req_idx] & (tags[req_idx] == req_tag);

  icache_line_ram u_ram (
    .clock (clock),
    .we    (ram_we),
    .waddr ({line_idx, cnt}),
    .wdata (mem_rdata),
    .raddr ({req_idx, req_off}),
    .rdata (ram_rdata)
  );

  // Next-state, fetch-side outputs and refill control.
  always_comb begin
    next_state   = state;
    cpu_stall    = 1'b0;
    cpu_rdata    = NOP;
    mem_addr     = cpu_addr;
    hit_inc      = 1'b0;
    miss_inc     = 1'b0;
    start_refill = 1'b0;
    fill_done    = 1'b0;
    ram_we       = 1'b0;
    unique case (state)
      IC_IDLE: begin
        if (hit) begin
          cpu_rdata = ram_rdata;
          hit_inc   = 1'b1;
        end else if (cpu_req) begin
          // A flush in the same cycle suppresses the refill; fetch simply retries.
          cpu_stall = 1'b1;
          if (!flush) begin
            miss_inc     = 1'b1;
            start_refill = 1'b1;
            next_state   = IC_REFILL;
          end
        end
      end
      IC_REFILL: begin
        cpu_stall = 1'b1;
        mem_addr  = {line_tag, line_idx, cnt};
        if (flush) begin
          next_state = IC_IDLE;
        end else begin
          ram_we = 1'b1;
          if (cnt == OFF_W'(3)) begin
            fill_done  = 1'b1;
            next_state = IC_IDLE;
          end
        end
      end
      default: next_state = IC_IDLE;
    endcase
    // Outputs show their reset values for as long as reset is held.
    if (reset) begin
      cpu_stall = 1'b0;
      cpu_rdata = NOP;
      mem_addr  = '0;
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IC_IDLE;
    else       state <= next_state;
  end

  // Line address latch and refill word counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      line_tag <= '0;
      line_idx <= '0;
    end else if (start_refill) begin
      cnt      <= '0;
      line_tag <= req_tag;
      line_idx <= req_idx;
    end else if (ram_we) begin
      cnt <= cnt + OFF_W'(1);
    end
  end

  // Valid bits and tags; flush beats a completing refill.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= '0;
      for (int i = 0; i < int'(LINES); i++) tags[i] <= '0;
    end else if (flush) begin
      valid <= '0;
    end else if (fill_done) begin
      valid[line_idx] <= 1'b1;
      tags[line_idx]  <= line_tag;
    end
  end

  // Saturating hit/miss performance counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit_inc)  hit_cnt  <= sat_inc(hit_cnt);
      if (miss_inc) miss_cnt <= sat_inc(miss_cnt);
    end
  end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache with a behavioural instruction memory.
module tb_icache;

  logic        clock;
  logic        reset;
  logic        cpu_req;
  logic [7:0]  cpu_addr;
  logic        flush;
  logic [15:0] cpu_rdata;
  logic        cpu_stall;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rdata;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  logic [15:0] imem [256];
  int checks;
  int fails;

  icache dut (
    .clock     (clock),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .flush     (flush),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  assign mem_rdata = imem[mem_addr];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic req, input logic [7:0] addr, input logic fl);
    cpu_req  = req;
    cpu_addr = addr;
    flush    = fl;
    #1;
  endtask

  // Checks the four refill cycles; entered with the FSM at the first refill word.
  task automatic refill_chk(input string tag, input logic [7:0] base);
    for (int k = 0; k < 4; k++) begin
      chk({tag, "_stall"}, 16'(cpu_stall), 16'h0001);
      chk({tag, "_maddr"}, 16'(mem_addr), 16'(base + 8'(k)));
      chk({tag, "_nop"}, cpu_rdata, 16'h0000);
      tick();
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    for (int i = 0; i < 256; i++) imem[i] = 16'hC000 | 16'(i);
    reset = 1'b1;
    drive(1'b1, 8'h55, 1'b0);
    tick();
    tick();
    // Reset state
    chk("rst_stall", 16'(cpu_stall), 16'h0000);
    chk("rst_rdata", cpu_rdata, 16'h0000);
    chk("rst_maddr", 16'(mem_addr), 16'h0000);
    chk("rst_hit", hit_cnt, 16'h0000);
    chk("rst_miss", miss_cnt, 16'h0000);
    reset = 1'b0;

    // 1: cold miss at 0x00, refill, then hit
    drive(1'b1, 8'h00, 1'b0);
    chk("t1_miss_stall", 16'(cpu_stall), 16'h0001);
    chk("t1_miss_nop", cpu_rdata, 16'h0000);
    tick();
    chk("t1_miss_cnt", miss_cnt, 16'h0001);
    refill_chk("t1_refill", 8'h00);
    chk("t1_hit_data", cpu_rdata, 16'hC000);
    chk("t1_hit_stall", 16'(cpu_stall), 16'h0000);
    chk("t1_miss_cnt6", miss_cnt, 16'h0001);
    tick();
    chk("t1_hit_cnt", hit_cnt, 16'h0001);

    // 2: sequential hits in the same line
    drive(1'b1, 8'h01, 1'b0);
    chk("t2_d1", cpu_rdata, 16'hC001);
    chk("t2_s1", 16'(cpu_stall), 16'h0000);
    tick();
    drive(1'b1, 8'h02, 1'b0);
    chk("t2_d2", cpu_rdata, 16'hC002);
    chk("t2_s2", 16'(cpu_stall), 16'h0000);
    tick();
    drive(1'b1, 8'h03, 1'b0);
    chk("t2_d3", cpu_rdata, 16'hC003);
    chk("t2_s3", 16'(cpu_stall), 16'h0000);
    tick();
    chk("t2_hit_cnt", hit_cnt, 16'h0004);
    chk("t2_miss_cnt", miss_cnt, 16'h0001);

    // 3: conflict on index 0
    drive(1'b1, 8'h21, 1'b0);
    chk("t3a_stall", 16'(cpu_stall), 16'h0001);
    tick();
    refill_chk("t3a_refill", 8'h20);
    chk("t3a_hit", cpu_rdata, 16'hC021);
    tick();
    drive(1'b1, 8'h00, 1'b0);
    chk("t3b_stall", 16'(cpu_stall), 16'h0001);
    tick();
    chk("t3b_miss_cnt", miss_cnt, 16'h0003);
    refill_chk("t3b_refill", 8'h00);
    chk("t3b_hit", cpu_rdata, 16'hC000);
    tick();
    chk("t3_hit_cnt", hit_cnt, 16'h0006);

    // Flush in IDLE: lookup uses pre-flush valids
    drive(1'b1, 8'h02, 1'b1);
    chk("fi_hit_data", cpu_rdata, 16'hC002);
    chk("fi_hit_stall", 16'(cpu_stall), 16'h0000);
    tick();
    chk("fi_hit_cnt", hit_cnt, 16'h0007);
    // Flush with a miss: no refill, no miss count
    drive(1'b1, 8'h10, 1'b1);
    chk("fm_stall", 16'(cpu_stall), 16'h0001);
    tick();
    chk("fm_miss_cnt", miss_cnt, 16'h0003);
    drive(1'b0, 8'h10, 1'b0);
    chk("fm_idle_stall", 16'(cpu_stall), 16'h0000);
    chk("fm_idle_maddr", 16'(mem_addr), 16'h0010);
    // Line 0 was invalidated by the flush
    drive(1'b1, 8'h00, 1'b0);
    chk("fm_line0_gone", 16'(cpu_stall), 16'h0001);
    drive(1'b0, 8'h00, 1'b0);

    // 4: flush during the 2nd refill cycle
    drive(1'b1, 8'h08, 1'b0);
    tick();
    chk("t4_miss_cnt", miss_cnt, 16'h0004);
    chk("t4_r1_maddr", 16'(mem_addr), 16'h0008);
    tick();
    drive(1'b1, 8'h08, 1'b1);
    chk("t4_r2_maddr", 16'(mem_addr), 16'h0009);
    chk("t4_r2_stall", 16'(cpu_stall), 16'h0001);
    tick();
    drive(1'b1, 8'h08, 1'b0);
    chk("t4_idle_maddr", 16'(mem_addr), 16'h0008);
    chk("t4_retry_stall", 16'(cpu_stall), 16'h0001);
    tick();
    chk("t4_miss_cnt2", miss_cnt, 16'h0005);
    refill_chk("t4_refill", 8'h08);
    chk("t4_hit", cpu_rdata, 16'hC008);
    tick();
    chk("t4_hit_cnt", hit_cnt, 16'h0008);

    // 5: reset during the 3rd refill cycle
    drive(1'b1, 8'h0C, 1'b0);
    tick();
    tick();
    tick();
    chk("t5_r3_maddr", 16'(mem_addr), 16'h000E);
    reset = 1'b1;
    #1;
    chk("t5_rst_stall", 16'(cpu_stall), 16'h0000);
    chk("t5_rst_rdata", cpu_rdata, 16'h0000);
    chk("t5_rst_maddr", 16'(mem_addr), 16'h0000);
    chk("t5_rst_hit", hit_cnt, 16'h0000);
    chk("t5_rst_miss", miss_cnt, 16'h0000);
    tick();
    reset = 1'b0;
    drive(1'b1, 8'h0C, 1'b0);
    chk("t5_remiss_stall", 16'(cpu_stall), 16'h0001);
    chk("t5_remiss_maddr", 16'(mem_addr), 16'h000C);
    tick();
    chk("t5_miss_cnt", miss_cnt, 16'h0001);
    refill_chk("t5_refill", 8'h0C);
    chk("t5_hit", cpu_rdata, 16'hC00C);
    tick();
    chk("t5_hit_cnt", hit_cnt, 16'h0001);

    // 6: idle fetch side on a warm cache
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 8'h0D, 1'b0);
      chk("t6_rdata", cpu_rdata, 16'h0000);
      chk("t6_stall", 16'(cpu_stall), 16'h0000);
      tick();
    end
    chk("t6_hit_cnt", hit_cnt, 16'h0001);
    chk("t6_miss_cnt", miss_cnt, 16'h0001);
    drive(1'b1, 8'h0D, 1'b0);
    chk("t6_warm_hit", cpu_rdata, 16'hC00D);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
